// File: rtl/riscv_pkg.sv
// Shared definitions for the unified-memory port arbiter of the RV32I core.
// Holds the requester source encodings, the default latency/fairness
// parameters and the layout of one response-pipeline entry.
package riscv_pkg;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_D  = 1'b1;

    localparam int MEM_LAT_DEF      = 1;
    localparam int MAX_D_STREAK_DEF = 4;

    localparam int RESP_VLD_W = 1;
    localparam int RESP_SRC_W = 1;
    localparam int RESP_WR_W  = 1;

    typedef struct packed {
        logic [RESP_VLD_W-1:0] vld;
        logic [RESP_SRC_W-1:0] src;
        logic [RESP_WR_W-1:0]  is_write;
    } resp_entry_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Response tracking pipeline for the unified-memory arbiter.
// A MEM_LAT-deep shift register of {valid, src, is_write} entries that
// advances every cycle, so the entry leaving the last stage lines up with
// the memory read data of the access that created it.
// Ports:
//   clk, rst                         clock, asynchronous active-high clear
//   in_vld, in_src, in_is_write      entry for the access granted this cycle
//   out_vld, out_src, out_is_write   entry whose memory data is valid now
module mem_resp_pipe
    import riscv_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  logic in_src,
    input  logic in_is_write,
    output logic out_vld,
    output logic out_src,
    output logic out_is_write
);

    resp_entry_t [MEM_LAT-1:0] resp_p;
    resp_entry_t               in_entry;

    assign in_entry = {in_vld, in_src, in_is_write};

    // stage 0 captures the grant; later stages follow one per cycle
    generate
        if (MEM_LAT == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    resp_p <= '0;
                end else begin
                    resp_p[0] <= in_entry;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    resp_p <= '0;
                end else begin
                    resp_p <= {resp_p[MEM_LAT-2:0], in_entry};
                end
            end
        end
    endgenerate

    // output stage: aligned with mem_rdata
    assign {out_vld, out_src, out_is_write} = resp_p[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, synchronous-read memory between the
// instruction-fetch port and the load/store port of the RV32I core.
// Data accesses win, except that a pending fetch is forced through after
// MAX_D_STREAK consecutive data grants. Read data is steered back to the
// requester that issued the access MEM_LAT cycles earlier.
// Ports:
//   clk, rst                                  clock, async active-high reset
//   if_req/if_addr -> if_gnt                  fetch request / accept (comb.)
//   if_rvalid, if_rdata                       fetch response
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt   load/store request / accept
//   d_rvalid, d_rdata                         load data or store acknowledge
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata   memory command
//   mem_rdata                                 memory read data (MEM_LAT later)
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = MEM_LAT_DEF,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                streak_limit;
    logic                rsp_vld_p;
    logic                rsp_src_p;
    logic                rsp_wr_p;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // arbitration: grants are suppressed while reset is held
    assign streak_limit = if_req && (streak == STREAK_MAX);
    assign d_gnt        = !rst && d_req && !streak_limit;
    assign if_gnt       = !rst && if_req && !d_gnt;
    assign mem_en       = if_gnt || d_gnt;

    // streak only counts data grants that actually delay a waiting fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (if_gnt || !if_req) begin
            streak <= '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_be    = '1;
            mem_addr  = if_addr;
        end
    end

    mem_resp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_resp_pipe (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (mem_en),
        .in_src       (d_gnt ? SRC_D : SRC_IF),
        .in_is_write  (d_gnt && d_we),
        .out_vld      (rsp_vld_p),
        .out_src      (rsp_src_p),
        .out_is_write (rsp_wr_p)
    );

    // response stage: memory data passes straight through on delivery,
    // the last delivered word is held in between
    assign if_rvalid = rsp_vld_p && (rsp_src_p == SRC_IF);
    assign d_rvalid  = rsp_vld_p && (rsp_src_p == SRC_D);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata   = d_rvalid ? (rsp_wr_p ? '0 : mem_rdata) : d_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_be_1;
    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_be_3;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd1;
    logic [31:0] rd3 [0:2];
    logic [9:0]  pat = 10'b1111011110;
    logic [31:0] bb_exp [0:4] = '{32'h000000A0, 32'h000000A1, 32'h000000A2,
                                  32'h000000A3, 32'h00500093};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_be(mem_be_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_D_STREAK(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_be(mem_be_3),
        .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared word-addressed memory; writes come from the MEM_LAT=1 instance
    // (both instances see identical stimulus and make identical grants).
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]   <= 32'h000000A0;
            mem[1]   <= 32'h000000A1;
            mem[2]   <= 32'h000000A2;
            mem[3]   <= 32'h000000A3;
            mem[4]   <= 32'h00500093;
            mem[5]   <= 32'h00000013;
            mem[64]  <= 32'hDEADBEEF;
            mem[128] <= 32'h11111111;
            rd1      <= 32'h0;
            for (int i = 0; i < 3; i++) rd3[i] <= 32'h0;
        end else begin
            if (mem_en_1) begin
                if (mem_we_1) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_1[b]) mem[mem_addr_1[9:2]][8*b +: 8] <= mem_wdata_1[8*b +: 8];
                end
                rd1 <= mem[mem_addr_1[9:2]];
            end
            rd3[0] <= mem_en_3 ? mem[mem_addr_3[9:2]] : 32'h0;
            rd3[1] <= rd3[0];
            rd3[2] <= rd3[1];
        end
    end

    assign mem_rdata_1 = rd1;
    assign mem_rdata_3 = rd3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
        tests++;
        assert (obs === req_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, req_v);
        end
    endtask

    initial begin
        // reset state, with both requests asserted to show grants are blocked
        rst = 1'b1;
        idle();
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_addr  = 32'h100;
        tick();
        tick();
        check("rst_ctl_1", 32'({if_gnt_1, d_gnt_1, mem_en_1, mem_we_1, mem_be_1, if_rvalid_1, d_rvalid_1}), 32'h0);
        check("rst_addr_1", mem_addr_1, 32'h0);
        check("rst_rdata_1", if_rdata_1 | d_rdata_1, 32'h0);
        check("rst_ctl_3", 32'({if_gnt_3, d_gnt_3, mem_en_3, mem_we_3, mem_be_3, if_rvalid_3, d_rvalid_3}), 32'h0);
        check("rst_addr_3", mem_addr_3 | mem_wdata_3, 32'h0);
        rst = 1'b0;
        idle();

        // single fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        #1;
        check("fetch_gnt", 32'({if_gnt_1, d_gnt_1, mem_en_1, mem_we_1, mem_be_1}), 32'hAF);
        check("fetch_addr", mem_addr_1, 32'h10);
        tick();
        idle();
        #1;
        check("fetch_rvalid", 32'({if_rvalid_1, d_rvalid_1}), 32'h2);
        check("fetch_rdata", if_rdata_1, 32'h00500093);
        tick();
        check("fetch_pulse", 32'({if_rvalid_1, d_rvalid_1}), 32'h0);
        check("fetch_hold", if_rdata_1, 32'h00500093);

        // collision: data first, fetch on the following cycle
        if_req  = 1'b1;
        if_addr = 32'h14;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        #1;
        check("coll_gnt", 32'({if_gnt_1, d_gnt_1}), 32'h1);
        check("coll_addr", mem_addr_1, 32'h100);
        tick();
        d_req = 1'b0;
        #1;
        check("coll_drsp", 32'({d_rvalid_1, if_rvalid_1}), 32'h2);
        check("coll_drdata", d_rdata_1, 32'hDEADBEEF);
        check("coll_if_gnt", 32'({if_gnt_1, d_gnt_1}), 32'h2);
        tick();
        idle();
        #1;
        check("coll_ifrsp", 32'({if_rvalid_1, d_rvalid_1}), 32'h2);
        check("coll_ifrdata", if_rdata_1, 32'h00000013);
        tick();

        // starvation guard: D,D,D,D,IF,D,D,D,D,IF
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_addr  = 32'h100;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("streak_%0d", i), 32'({d_gnt_1, if_gnt_1}), pat[9-i] ? 32'h2 : 32'h1);
            tick();
        end
        if_req = 1'b0;
        #1;
        check("streak_drain", 32'({d_gnt_1, if_gnt_1}), 32'h2);
        tick();
        idle();
        tick();
        tick();

        // store with partial byte enables, then load it back
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h200;
        d_wdata = 32'hCAFEF00D;
        #1;
        check("st_cmd", 32'({d_gnt_1, mem_we_1, mem_be_1}), 32'h33);
        check("st_wdata", mem_wdata_1, 32'hCAFEF00D);
        tick();
        d_we = 1'b0;
        d_be = 4'hF;
        #1;
        check("st_ack", 32'({d_rvalid_1, d_gnt_1}), 32'h3);
        check("st_ack_data", d_rdata_1, 32'h0);
        tick();
        idle();
        #1;
        check("ld_rvalid", 32'(d_rvalid_1), 32'h1);
        check("ld_rdata", d_rdata_1, 32'h1111F00D);
        tick();
        tick();
        tick();
        tick();

        // reset between a load's grant and its response (MEM_LAT=3)
        d_req  = 1'b1;
        d_addr = 32'h100;
        #1;
        check("rmf_gnt", 32'(d_gnt_3), 32'h1);
        tick();
        d_req = 1'b0;
        #2;
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        #1;
        check("rmf_ctl", 32'({if_gnt_3, d_gnt_3, mem_en_3, mem_we_3, mem_be_3, if_rvalid_3, d_rvalid_3}), 32'h0);
        check("rmf_addr", mem_addr_3 | mem_wdata_3, 32'h0);
        check("rmf_rdata", if_rdata_3 | d_rdata_3, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("rmf_no_rsp_%0d", i), 32'({d_rvalid_3, if_rvalid_3}), 32'h0);
            tick();
        end

        // fetch after reset release completes normally
        if_req  = 1'b1;
        if_addr = 32'h10;
        #1;
        check("post_rst_gnt", 32'(if_gnt_3), 32'h1);
        tick();
        idle();
        #1;
        check("post_rst_early", 32'(if_rvalid_3), 32'h0);
        tick();
        tick();
        check("post_rst_rvalid", 32'({if_rvalid_3, d_rvalid_3}), 32'h2);
        check("post_rst_rdata", if_rdata_3, 32'h00500093);
        tick();

        // five back-to-back fetches, MEM_LAT=3
        for (int k = 0; k < 9; k++) begin
            if_req  = (k < 5);
            if_addr = 32'(k * 4);
            #1;
            check($sformatf("b2b_gnt_%0d", k), 32'(if_gnt_3), 32'(k < 5));
            check($sformatf("b2b_rvalid_%0d", k), 32'(if_rvalid_3), 32'((k >= 3) && (k < 8)));
            if ((k >= 3) && (k < 8))
                check($sformatf("b2b_rdata_%0d", k), if_rdata_3, bb_exp[k-3]);
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory between the instruction-fetch port and the load/store port of the RV32I core.
- Used when instruction and data memory are merged into one array.
- Each cycle it grants at most one requester, drives the memory port, and routes the read data back to the correct requester after a fixed latency.
- The core stalls on whichever port is not granted.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: data width. Fixed at 32 for RV32I; the byte enables are DATA_W/8 bits wide.
- MEM_LAT, 1: memory read latency in cycles, from mem_en to valid mem_rdata. Legal range is 1 to 4.
- MAX_D_STREAK, 4: maximum number of consecutive data grants allowed while a fetch request is pending.

Ports:
- clk  in  1  Core clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- if_req  in  1  Fetch request. Held until if_gnt is seen.
- if_addr  in  ADDR_W  Fetch address. Word aligned.
- if_gnt  out  1  Fetch accepted this cycle. Combinational.
- if_rvalid  out  1  Fetch data valid.
- if_rdata  out  DATA_W  Fetch data.
- d_req  in  1  Data request. Held, with its payload, until d_gnt is seen.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  Byte enables for stores.
- d_addr  in  ADDR_W  Data address.
- d_wdata  in  DATA_W  Store data.
- d_gnt  out  1  Data request accepted this cycle. Combinational.
- d_rvalid  out  1  Load data valid, or store-complete acknowledge.
- d_rdata  out  DATA_W  Load data. Zero for store acknowledges.
- mem_en  out  1  Memory access this cycle.
- mem_we  out  1  Memory write.
- mem_be  out  4  Memory byte enables.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_rdata  in  DATA_W  Memory read data. Valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, rst=1):
  - streak counter = 0.
  - response pipeline cleared.
  - if_rvalid = d_rvalid = 0; if_rdata = d_rdata = 0.
  - gnt outputs are 0 while rst=1.
- Reset asserted mid-operation: in-flight responses are discarded, and no rvalid is issued for them after reset is released.
- Arbitration (combinational, one grant per cycle):
  - Data has priority: d_gnt = d_req, unless the streak limit applies.
  - Streak limit: if streak == MAX_D_STREAK and if_req=1, then if_gnt=1 and d_gnt=0.
  - Otherwise if_gnt = if_req & ~d_gnt.
  - No requests means no grant and mem_en=0.
- Streak counter:
  - Increments on a d_gnt cycle while if_req=1, saturating at MAX_D_STREAK.
  - Clears on any if_gnt, or on any cycle with if_req=0.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - Address, we, be and wdata come from the granted port.
  - Fetch accesses drive mem_we=0 and mem_be=4'hF.
  - When idle, mem_addr, mem_wdata and mem_be are 0.
- Response routing:
  - A MEM_LAT-deep shift register of {valid, src, is_write} entries is advanced every cycle.
  - Granted accesses enter at stage 0.
  - At the output stage:
    - src=IF: if_rvalid=1 and if_rdata=mem_rdata.
    - src=D, load: d_rvalid=1 and d_rdata=mem_rdata.
    - src=D, store: d_rvalid=1 and d_rdata=0.
  - rvalid is a one-cycle pulse; rdata holds its value otherwise.
- Latency: a grant in cycle N gives rvalid in cycle N+MEM_LAT. Back-to-back grants give back-to-back responses, with full throughput of 1 access per cycle.
- Simultaneous events:
  - A new grant and a response delivery in the same cycle are both handled.
  - Responses to the two ports never coincide, because only one grant is issued per cycle.
- Protocol violations: a request that drops before its grant is simply not serviced. The bench flags it as a protocol error; the RTL does not check for it.
- Address misalignment: the arbiter passes addresses through unchanged. Alignment is the core's responsibility.

Decomposition:
- Package riscv_pkg (in the existing RISCV_PKG.vh) holds:
  - SRC_IF=1'b0 and SRC_D=1'b1.
  - The default MEM_LAT and MAX_D_STREAK values.
  - The response-entry field widths.
- One sub-module, mem_resp_pipe: the MEM_LAT-deep valid/src/is_write shift register with asynchronous clear.
- Arbitration and the streak counter stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x10, memory word = 0x00500093.
  - Required: if_gnt=1 the same cycle; if_rvalid=1 with if_rdata=0x00500093 exactly 1 cycle later; no d_rvalid.
- Collision:
  - Stimulus: if_req and d_req both high in one cycle; load from 0x100 holding 0xDEADBEEF.
  - Required: d_gnt=1 and if_gnt=0; d_rdata=0xDEADBEEF next cycle; if_gnt follows in the next cycle.
- Starvation guard:
  - Stimulus: d_req held high for 10 cycles with if_req also high; MAX_D_STREAK=4.
  - Required: grant pattern D,D,D,D,IF,D,D,D,D,IF.
- Store then load:
  - Stimulus: store 0xCAFEF00D with d_be=4'b0011 to 0x200 (old value 0x11111111); then load 0x200.
  - Required: store ack with d_rdata=0; load returns 0x1111F00D.
- Reset mid-flight:
  - Stimulus: assert rst for one cycle, asynchronously, between a load's grant and its response.
  - Required: no d_rvalid for that load; all outputs 0 during reset; a new fetch after release completes normally.
- MEM_LAT=3 back-to-back:
  - Stimulus: 5 consecutive fetches at 0x0, 0x4, 0x8, 0xC, 0x10.
  - Required: if_rvalid is high for 5 consecutive cycles starting 3 cycles after the first grant, with data in order.
